// File: rtl/ctrl_mem_pkg.sv
// Shared types for the ctrl_mem read/write controllers: FSM state encoding and
// the run counter type (one bit wider than the memory address).
package ctrl_mem_pkg;

  localparam int unsigned CM_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [CM_ADDR_W:0] cnt_t;

endpackage

// File: rtl/ctrl_mem_rd_buf.sv
// Two-entry output FIFO for ctrl_mem_read, plus its overflow/underflow checker.
// With CTRL_MEM_READ_LAST_EN defined each entry also carries a last flag.
module ctrl_mem_rd_buf #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
`ifdef CTRL_MEM_READ_LAST_EN
  input  logic                  push_last,
  output logic                  head_last,
`endif
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] r_data [2];
`ifdef CTRL_MEM_READ_LAST_EN
  logic                  r_last [2];
`endif
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_occ;

  // storage, pointers and occupancy; simultaneous push/pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
`ifdef CTRL_MEM_READ_LAST_EN
      r_last[0] <= 1'b0;
      r_last[1] <= 1'b0;
`endif
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_occ     <= 2'd0;
    end else begin
      if (push) begin
        r_data[r_tail] <= push_data;
`ifdef CTRL_MEM_READ_LAST_EN
        r_last[r_tail] <= push_last;
`endif
        r_tail         <= ~r_tail;
      end
      if (pop) begin
        r_head <= ~r_head;
      end
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head_data = r_data[r_head];
`ifdef CTRL_MEM_READ_LAST_EN
  assign head_last = r_last[r_head];
`endif
  assign occ       = r_occ;

  ctrl_mem_rd_buf_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .occ   (r_occ)
  );

endmodule

// Occupancy checker for the two-entry buffer.
module ctrl_mem_rd_buf_chk (
  input logic       clk,
  input logic       reset,
  input logic       push,
  input logic       pop,
  input logic [1:0] occ
);

  // a push into a full buffer without a pop, or a pop from empty, is a design error
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && (occ == 2'd2))) else $error("ctrl_mem_rd_buf overflow");
      assert (!(pop && (occ == 2'd0)))          else $error("ctrl_mem_rd_buf underflow");
    end
  end

endmodule

// File: rtl/ctrl_mem_read.sv
// Streams MEM_SIZE words from a 1-cycle-latency memory over a valid/ready master.
// Optional m_last output is enabled by defining CTRL_MEM_READ_LAST_EN.
module ctrl_mem_read
  import ctrl_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = CM_ADDR_W,
  parameter int MEM_SIZE       = 8,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_rd_en,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_valid,
`ifdef CTRL_MEM_READ_LAST_EN
  output logic                      m_last,
`endif
  input  logic                      m_ready,
  output logic                      busy,
  output logic                      done
);

  localparam cnt_t                      LAST_CNT  = cnt_t'(MEM_SIZE - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  cnt_t                      r_issue_cnt;
  cnt_t                      r_accept_cnt;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic                      r_inflight;
  logic                      r_done;
  logic [1:0]                w_occ;
  logic [2:0]                w_fill;
  logic [DATA_WIDTH-1:0]     w_head;
  logic                      w_pop;
  logic                      w_issue;
  logic                      w_last_issue;
  logic                      w_last_pop;
`ifdef CTRL_MEM_READ_LAST_EN
  logic                      r_inflight_last;
  logic                      w_head_last;
`endif

  // Words already buffered or in flight, minus the one leaving now, must leave room.
  assign w_pop   = (w_occ != 2'd0) && m_ready;
  assign w_fill  = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_issue = (r_state == READ) && (w_fill <= ({2'b00, w_pop} + 3'd1));

  // next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_last_issue = w_issue && (r_issue_cnt == LAST_CNT);
    w_last_pop   = w_pop && (r_accept_cnt == LAST_CNT);
    case (r_state)
      IDLE:    if (start) w_state_nxt = READ;  else w_state_nxt = IDLE;
      READ:    if (w_last_issue) w_state_nxt = DRAIN; else w_state_nxt = READ;
      DRAIN:   if (w_last_pop) w_state_nxt = IDLE;  else w_state_nxt = DRAIN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, counters, address and in-flight tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_issue_cnt  <= '0;
      r_accept_cnt <= '0;
      r_addr       <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      r_done     <= (r_state == DRAIN) && w_last_pop;
      if ((r_state == IDLE) && start) begin
        r_issue_cnt  <= '0;
        r_accept_cnt <= '0;
        r_addr       <= '0;
      end else begin
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + cnt_t'(1);
          r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + MEM_ADDR_WIDTH'(1);
        end
        if (w_pop) begin
          r_accept_cnt <= r_accept_cnt + cnt_t'(1);
        end
      end
    end
  end

`ifdef CTRL_MEM_READ_LAST_EN
  // remembers whether the word in flight came from the final address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight_last <= w_issue && (r_addr == LAST_ADDR);
    end
  end
`endif

  ctrl_mem_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (r_inflight),
    .push_data (mem_rd_data),
`ifdef CTRL_MEM_READ_LAST_EN
    .push_last (r_inflight_last),
    .head_last (w_head_last),
`endif
    .pop       (w_pop),
    .head_data (w_head),
    .occ       (w_occ)
  );

  assign mem_addr  = r_addr;
  assign mem_rd_en = w_issue;
  assign m_data    = w_head;
  assign m_valid   = (w_occ != 2'd0);
`ifdef CTRL_MEM_READ_LAST_EN
  assign m_last    = w_head_last;
`endif
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_ctrl_mem_read.sv
// Directed bench for ctrl_mem_read against a memory preloaded with mem[i]=16'h00A0+i.
module tb_ctrl_mem_read;

  localparam int AW   = 3;
  localparam int N    = 8;
  localparam int DW   = 16;
  localparam int RUNS = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          m_ready;
  logic [DW-1:0] mem_rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          busy;
  logic          done;
`ifdef CTRL_MEM_READ_LAST_EN
  logic          m_last;
`endif

  logic [DW-1:0] mem [N];
  int            total = 0;
  int            bad   = 0;

  ctrl_mem_read #(
    .MEM_ADDR_WIDTH (AW),
    .MEM_SIZE       (N),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_rd_data (mem_rd_data),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
`ifdef CTRL_MEM_READ_LAST_EN
    .m_last      (m_last),
`endif
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return 32'h0000_00A0 + 32'(k);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // start in the current cycle with m_ready high and check the ideal timeline
  task automatic basic_run();
    @(negedge clk); start = 1'b1; m_ready = 1'b1; #1;
    check("basic_idle_busy", 32'(busy), 32'd0);
    @(negedge clk); start = 1'b0; #1;
    check("basic_first_en", 32'(mem_rd_en), 32'd1);
    check("basic_first_addr", 32'(mem_addr), 32'd0);
    check("basic_busy", 32'(busy), 32'd1);
    tick();
    check("basic_no_valid_yet", 32'(m_valid), 32'd0);
    for (int k = 0; k < N; k++) begin
      tick();
      check("basic_valid", 32'(m_valid), 32'd1);
      check("basic_data", 32'(m_data), exp_word(k));
      check("basic_done_early", 32'(done), 32'd0);
`ifdef CTRL_MEM_READ_LAST_EN
      check("basic_last", 32'(m_last), 32'(k == N - 1));
`endif
    end
    tick();
    check("basic_done", 32'(done), 32'd1);
    check("basic_done_busy", 32'(busy), 32'd0);
    check("basic_done_valid", 32'(m_valid), 32'd0);
    tick();
    check("basic_done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    int   r;
    int   beats;
    int   dones;
    int   cyc;
    int   occ_m;
    logic infl_m;
    logic pop;

    for (int i = 0; i < N; i++) mem[i] = 16'h00A0 + 16'(i);
    reset = 1'b1; start = 1'b0; m_ready = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_en", 32'(mem_rd_en), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef CTRL_MEM_READ_LAST_EN
    check("rst_last", 32'(m_last), 32'd0);
`endif
    @(negedge clk); reset = 1'b0; #1;

    // basic bubble-free stream
    basic_run();

    // backpressure: ready low for 6 cycles from the first valid
    @(negedge clk); m_ready = 1'b0; start = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
    check("bp_en_t1", 32'(mem_rd_en), 32'd1);
    check("bp_addr_t1", 32'(mem_addr), 32'd0);
    tick();
    check("bp_en_t2", 32'(mem_rd_en), 32'd1);
    check("bp_addr_t2", 32'(mem_addr), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_valid", 32'(m_valid), 32'd1);
      check("bp_hold_data", 32'(m_data), exp_word(0));
      check("bp_stall_en", 32'(mem_rd_en), 32'd0);
    end
    @(negedge clk); m_ready = 1'b1; #1;
    check("bp_resume_en", 32'(mem_rd_en), 32'd1);
    beats = 0; cyc = 0;
    while (beats < N && cyc < 50) begin
      if (m_valid && m_ready) begin
        check("bp_data", 32'(m_data), exp_word(beats));
        beats++;
      end
      tick();
      cyc++;
    end
    check("bp_beats", 32'(beats), 32'(N));
    check("bp_done", 32'(done), 32'd1);
    tick();

    // random ready, next start issued in each done cycle
    @(negedge clk); start = 1'b1; m_ready = 1'b0; #1;
    r = 0; beats = 0; cyc = 0; occ_m = 0; infl_m = 1'b0;
    while (r < RUNS && cyc < 20000) begin
      @(negedge clk); start = 1'b0; m_ready = 1'($urandom_range(0, 1)); #1;
      cyc++;
      pop = m_valid && m_ready;
      check("rand_valid", 32'(m_valid), 32'(occ_m != 0));
      check("rand_no_ovf", 32'(mem_rd_en && (occ_m == 2) && !pop), 32'd0);
      if (pop) begin
        check("rand_data", 32'(m_data), exp_word(beats));
`ifdef CTRL_MEM_READ_LAST_EN
        check("rand_last", 32'(m_last), 32'(beats == N - 1));
`endif
        beats++;
      end
      if (done) begin
        check("rand_beats", 32'(beats), 32'(N));
        beats = 0;
        r++;
        start = (r < RUNS);
      end
      occ_m  = occ_m + int'(infl_m) - int'(pop);
      infl_m = mem_rd_en;
    end
    check("rand_runs", 32'(r), 32'(RUNS));
    start = 1'b0;
    repeat (2) tick();

    // start pulsed at beat 3 while busy is ignored
    @(negedge clk); start = 1'b1; m_ready = 1'b1; #1;
    beats = 0; dones = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk); start = (c == 6); #1;
      if (m_valid && m_ready) begin
        check("busy_start_data", 32'(m_data), exp_word(beats));
        beats++;
      end
      if (done) dones++;
    end
    start = 1'b0;
    check("busy_start_beats", 32'(beats), 32'(N));
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // reset right after the A4 handshake with a read in flight
    @(negedge clk); start = 1'b1; m_ready = 1'b1; #1;
    @(negedge clk); start = 1'b0; #1;
    repeat (5) tick();
    tick();
    check("mid_a4_data", 32'(m_data), exp_word(4));
    check("mid_a4_valid", 32'(m_valid), 32'd1);
    check("mid_inflight", 32'(mem_rd_en), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    check("mid_rst_en", 32'(mem_rd_en), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    check("mid_discard_valid", 32'(m_valid), 32'd0);
    basic_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
